// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the convolution result sequencer and the layer controller.
package cnn_seq_pkg;

  // Pixels per output channel for each convolution layer
  localparam int unsigned C1_DEPTH = 784;
  localparam int unsigned C3_DEPTH = 100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    DRAIN = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/seq_counter.sv
// Up-counter with synchronous clear, count enable and a terminal-count compare.
module seq_counter #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_tc,
  output logic [W-1:0] o_cnt,
  output logic         o_tc_hit
);

  logic [W-1:0] r_cnt;

  // Clear takes priority over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_en)    r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt    = r_cnt;
  assign o_tc_hit = (r_cnt == i_tc);

endmodule

// File: rtl/conv_result_sequencer.sv
// Sequences the per-layer convolution result buffer: write window, drain, read window.
module conv_result_sequencer #(
  parameter int unsigned C1_DEPTH  = cnn_seq_pkg::C1_DEPTH,
  parameter int unsigned C3_DEPTH  = cnn_seq_pkg::C3_DEPTH,
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned RD_TMO    = 4095,
  parameter int unsigned CNT_W     = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             layer_c1,
  input  logic             abort,
  input  logic             pix_valid,
  input  logic             quantifyFinish,
  output logic             stateC1,
  output logic             convStart,
  output logic             convFinish_flag,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pix_cnt
);

  import cnn_seq_pkg::*;

  seq_state_t       r_state;
  seq_state_t       w_next;

  logic             r_c1;
  logic             r_conv_start;
  logic             r_finish;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_pix_clr;
  logic             w_pix_en;
  logic             w_err_set;
  logic [CNT_W-1:0] w_pix_cnt;
  logic [CNT_W-1:0] w_pix_tc;
  logic             w_pix_hit;
  logic             w_in_drain;
  logic             w_in_read;
  logic             w_drain_hit;
  logic             w_tmo_hit;
  logic [CNT_W-1:0] w_drain_cnt_unused;
  logic [CNT_W-1:0] w_rd_cnt_unused;

  assign w_pix_tc   = r_c1 ? CNT_W'(C1_DEPTH - 1) : CNT_W'(C3_DEPTH - 1);
  assign w_in_drain = (r_state == DRAIN);
  assign w_in_read  = (r_state == READ);

  seq_counter #(.W(CNT_W)) u_pix_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_pix_clr),
    .i_en     (w_pix_en),
    .i_tc     (w_pix_tc),
    .o_cnt    (w_pix_cnt),
    .o_tc_hit (w_pix_hit)
  );

  // Drain and read timers sit at zero outside their own state
  seq_counter #(.W(CNT_W)) u_drain_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (!w_in_drain),
    .i_en     (w_in_drain),
    .i_tc     (CNT_W'(DRAIN_CYC - 1)),
    .o_cnt    (w_drain_cnt_unused),
    .o_tc_hit (w_drain_hit)
  );

  seq_counter #(.W(CNT_W)) u_rd_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (!w_in_read),
    .i_en     (w_in_read),
    .i_tc     (CNT_W'(RD_TMO - 1)),
    .o_cnt    (w_rd_cnt_unused),
    .o_tc_hit (w_tmo_hit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and counter controls; abort overrides every other event
  always_comb begin
    w_next    = r_state;
    w_pix_clr = 1'b0;
    w_pix_en  = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next    = WRITE;
          w_pix_clr = 1'b1;
        end
      end
      WRITE: begin
        if (pix_valid) begin
          w_pix_en = 1'b1;
          if (w_pix_hit) w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drain_hit) w_next = READ;
      end
      READ: begin
        if (quantifyFinish) begin
          w_next = DONE;
        end else if (w_tmo_hit) begin
          w_next    = IDLE;
          w_err_set = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort) begin
      w_next    = IDLE;
      w_pix_clr = 1'b0;
      w_pix_en  = 1'b0;
      w_err_set = 1'b0;
    end
  end

  // Outputs registered from the next state so they switch together with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c1         <= 1'b0;
      r_conv_start <= 1'b0;
      r_finish     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_pix_clr) r_c1 <= layer_c1;
      r_conv_start <= (w_next == WRITE) || (w_next == DRAIN);
      r_finish     <= (w_next == READ);
      r_busy       <= (w_next != IDLE);
      r_done       <= (w_next == DONE);
      r_err        <= w_err_set;
    end
  end

  assign stateC1         = r_c1;
  assign convStart       = r_conv_start;
  assign convFinish_flag = r_finish;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;
  assign pix_cnt         = w_pix_cnt;

endmodule

// File: tb/tb_conv_result_sequencer.sv
// Directed/randomized bench for conv_result_sequencer.
module tb_conv_result_sequencer;

  localparam int unsigned N_C1  = 784;
  localparam int unsigned N_C3  = 100;
  localparam int unsigned DRAIN = 2;
  localparam int unsigned TMO   = 4095;
  localparam int unsigned CW    = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          layer_c1;
  logic          abort;
  logic          pix_valid;
  logic          quantifyFinish;
  logic          stateC1;
  logic          convStart;
  logic          convFinish_flag;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] pix_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_result_sequencer #(
    .C1_DEPTH  (N_C1),
    .C3_DEPTH  (N_C3),
    .DRAIN_CYC (DRAIN),
    .RD_TMO    (TMO),
    .CNT_W     (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .layer_c1        (layer_c1),
    .abort           (abort),
    .pix_valid       (pix_valid),
    .quantifyFinish  (quantifyFinish),
    .stateC1         (stateC1),
    .convStart       (convStart),
    .convFinish_flag (convFinish_flag),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .pix_cnt         (pix_cnt)
  );

  function automatic int unsigned depth(input bit c1);
    return c1 ? N_C1 : N_C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_c1"},   stateC1, 0);
    chk({tag, "_cs"},   convStart, 0);
    chk({tag, "_cf"},   convFinish_flag, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"},  err, 0);
    chk({tag, "_cnt"},  pix_cnt, 0);
  endtask

  // Start a run, feed all pixels with gaps in [gmin,gmax], pass through drain into READ.
  // flip_at: pixel index before which a bogus start with the other layer is pulsed.
  task automatic run_write(input bit c1, input int gmin, input int gmax, input int flip_at);
    int unsigned n;
    int g;
    n = depth(c1);
    start = 1'b1; layer_c1 = c1; pix_valid = 1'b0;
    tick();
    start = 1'b0; layer_c1 = 1'($urandom);
    chk("start_busy", busy, 1);
    chk("start_cs",   convStart, 1);
    chk("start_cf",   convFinish_flag, 0);
    chk("start_c1",   stateC1, c1);
    chk("start_cnt",  pix_cnt, 0);
    for (int k = 1; k <= int'(n); k++) begin
      g = int'($urandom_range(gmax, gmin));
      for (int j = 0; j < g; j++) begin
        quantifyFinish = 1'($urandom);
        if (k == flip_at && j == 0) begin
          start = 1'b1; layer_c1 = !c1;
        end
        tick();
        start = 1'b0; quantifyFinish = 1'b0;
      end
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      chk("pix_cnt", pix_cnt, k);
      chk("pix_c1",  stateC1, c1);
    end
    for (int d = 0; d < int'(DRAIN); d++) begin
      chk("drain_cs",   convStart, 1);
      chk("drain_cf",   convFinish_flag, 0);
      chk("drain_cnt",  pix_cnt, n);
      chk("drain_done", done, 0);
      pix_valid = 1'($urandom);
      tick();
      pix_valid = 1'b0;
    end
    chk("read_cs",  convStart, 0);
    chk("read_cf",  convFinish_flag, 1);
    chk("read_cnt", pix_cnt, n);
    chk("read_c1",  stateC1, c1);
  endtask

  // Assert quantifyFinish in the q-th READ cycle, expect a one-cycle done pulse.
  task automatic read_done(input bit c1, input int q);
    for (int i = 1; i < q; i++) begin
      tick();
      chk("rd_hold_cf",   convFinish_flag, 1);
      chk("rd_hold_done", done, 0);
    end
    quantifyFinish = 1'b1;
    tick();
    quantifyFinish = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_cf",    convFinish_flag, 0);
    chk("done_cs",    convStart, 0);
    chk("done_busy",  busy, 1);
    chk("done_err",   err, 0);
    chk("done_c1",    stateC1, c1);
    tick();
    chk("post_done",  done, 0);
    chk("post_busy",  busy, 0);
    chk("post_c1",    stateC1, c1);
  endtask

  initial begin
    int cyc;

    // Reset
    rst_n = 1'b0; start = 1'b0; layer_c1 = 1'b0; abort = 1'b0;
    pix_valid = 1'b0; quantifyFinish = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // start with abort in IDLE is overridden
    start = 1'b1; layer_c1 = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_c1",   stateC1, 0);

    // C3 run, random gaps, quantifyFinish in the 5th READ cycle
    run_write(1'b0, 0, 2, -1);
    read_done(1'b0, 5);

    // C1 run, one pixel every 3 cycles, bogus start mid-write
    run_write(1'b1, 2, 2, 300);
    read_done(1'b1, int'($urandom_range(20, 1)));

    // Abort together with a pixel at count 50
    start = 1'b1; layer_c1 = 1'b0;
    tick();
    start = 1'b0;
    pix_valid = 1'b1;
    repeat (50) tick();
    chk("abort_pre_cnt", pix_cnt, 50);
    abort = 1'b1;
    tick();
    abort = 1'b0; pix_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cs",   convStart, 0);
    chk("abort_cnt",  pix_cnt, 50);
    repeat (3) tick();
    chk("abort_done", done, 0);
    chk("abort_err",  err, 0);
    chk("abort_hold", pix_cnt, 50);

    // Read timeout
    run_write(1'b0, 0, 1, -1);
    cyc = 0;
    while (err !== 1'b1 && cyc < int'(TMO) + 8) begin
      tick();
      cyc++;
    end
    chk("tmo_cycles", cyc, TMO);
    chk("tmo_busy",   busy, 0);
    chk("tmo_cf",     convFinish_flag, 0);
    chk("tmo_done",   done, 0);
    tick();
    chk("tmo_err_off", err, 0);

    // Asynchronous reset in the middle of READ, then a clean run
    run_write(1'b1 == 1'b0, 0, 0, -1);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_idle_busy", busy, 0);
    run_write(1'b0, 0, 1, -1);
    read_done(1'b0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
